// File: rtl/ram_access_ctrl_if.sv
// Bundle of the fetch port, load/store port and RAM-side bus of ram_access_ctrl.
// master is the controller's view (it is the only master of the RAM); slave is the environment's view.
interface ram_access_ctrl_if;
  logic        if_req;
  logic [7:0]  if_addr;
  logic [31:0] if_data;
  logic        if_ack;
  logic        d_req;
  logic [5:0]  d_opcode;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        err;
  logic        busy;
  logic        mem_mfa;
  logic [5:0]  mem_opcode;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_mfc;

  modport master (
    input  if_req, if_addr, d_req, d_opcode, d_addr, d_wdata, mem_rdata, mem_mfc,
    output if_data, if_ack, d_rdata, d_ack, err, busy,
           mem_mfa, mem_opcode, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_opcode, d_addr, d_wdata, mem_rdata, mem_mfc,
    input  if_data, if_ack, d_rdata, d_ack, err, busy,
           mem_mfa, mem_opcode, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// MFA/MFC sequencer sharing the 256-byte RAM between fetch (F) and load/store (D) ports.
// Optional macro ALIGN_CHECK_EN rejects misaligned halfword/word accesses without touching the RAM.
module ram_access_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input logic               clk,
  input logic               rst_n,
  ram_access_ctrl_if.master bus
);

  localparam logic [5:0] OP_LD   = 6'b001000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t     state, state_nx;
  logic       last_grant_d;
  logic       grant_d;
  logic [7:0] wait_cnt;
  logic       d_elig, f_elig, pick_d, pick_f;
  logic       d_ok, f_ok;
  logic       mem_is_store;
  logic       timeout_hit;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH, OP_ST, OP_STB, OP_STH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_aligned(input logic [5:0] op, input logic [7:0] addr);
    case (op)
      OP_LDUH, OP_LDSH, OP_STH: return !ALIGN_EN || (addr[0] == 1'b0);
      OP_LD, OP_ST:             return !ALIGN_EN || (addr[1:0] == 2'b00);
      default:                  return 1'b1;
    endcase
  endfunction

  // A requester still sees its own ack pulse high for one cycle after a
  // rejected grant; masking it keeps that held request from being re-granted.
  assign d_elig = bus.d_req & ~bus.d_ack;
  assign f_elig = bus.if_req & ~bus.if_ack;
  assign pick_d = d_elig && !(last_grant_d && f_elig);
  assign pick_f = !pick_d && f_elig;
  assign d_ok   = op_supported(bus.d_opcode) && op_aligned(bus.d_opcode, bus.d_addr);
  assign f_ok   = op_aligned(OP_LD, bus.if_addr);

  assign mem_is_store = (bus.mem_opcode == OP_ST) || (bus.mem_opcode == OP_STB) ||
                        (bus.mem_opcode == OP_STH);
  assign timeout_hit  = (wait_cnt == TIMEOUT_LAST);

  assign bus.mem_mfa = (state == S_ASSERT) || (state == S_WAIT);
  assign bus.busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if ((pick_d && d_ok) || (pick_f && f_ok)) state_nx = S_ASSERT;
      S_ASSERT:  state_nx = S_WAIT;
      S_WAIT:    if (bus.mem_mfc || timeout_hit) state_nx = S_RELEASE;
      S_RELEASE: if (!bus.mem_mfc) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_d   <= 1'b0;
      grant_d        <= 1'b0;
      wait_cnt       <= '0;
      bus.if_data    <= '0;
      bus.if_ack     <= 1'b0;
      bus.d_rdata    <= '0;
      bus.d_ack      <= 1'b0;
      bus.err        <= 1'b0;
      bus.mem_opcode <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.if_ack <= 1'b0;
      bus.d_ack  <= 1'b0;
      bus.err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_d) begin
            last_grant_d <= 1'b1;
            if (d_ok) begin
              grant_d        <= 1'b1;
              bus.mem_opcode <= bus.d_opcode;
              bus.mem_addr   <= bus.d_addr;
              bus.mem_wdata  <= bus.d_wdata;
            end else begin
              bus.d_ack <= 1'b1;
              bus.err   <= 1'b1;
            end
          end else if (pick_f) begin
            last_grant_d <= 1'b0;
            if (f_ok) begin
              grant_d        <= 1'b0;
              bus.mem_opcode <= OP_LD;
              bus.mem_addr   <= bus.if_addr;
              bus.mem_wdata  <= '0;
            end else begin
              bus.if_ack <= 1'b1;
              bus.err    <= 1'b1;
            end
          end
        end
        S_ASSERT: wait_cnt <= '0;
        S_WAIT: begin
          if (bus.mem_mfc) begin
            if (!mem_is_store) begin
              if (grant_d) bus.d_rdata <= bus.mem_rdata;
              else         bus.if_data <= bus.mem_rdata;
            end
            if (grant_d) bus.d_ack  <= 1'b1;
            else         bus.if_ack <= 1'b1;
          end else if (timeout_hit) begin
            if (grant_d) bus.d_ack  <= 1'b1;
            else         bus.if_ack <= 1'b1;
            bus.err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: big-endian combinational RAM model plus a transaction-level
// reference (shadow byte array, expected latency/err/data). Honours ALIGN_CHECK_EN when defined.
module tb_ram_access_ctrl;
  localparam int unsigned TIMEOUT_CYC = 15;

  localparam logic [5:0] LD   = 6'b001000;
  localparam logic [5:0] LDUB = 6'b000001;
  localparam logic [5:0] LDUH = 6'b000010;
  localparam logic [5:0] LDSB = 6'b001001;
  localparam logic [5:0] LDSH = 6'b001010;
  localparam logic [5:0] ST   = 6'b000100;
  localparam logic [5:0] STB  = 6'b000101;
  localparam logic [5:0] STH  = 6'b000110;
  localparam logic [5:0] LDD  = 6'b000011;
  localparam logic [5:0] STD  = 6'b000111;

`ifdef ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic mfc_kill = 1'b0;
  always #5 clk = ~clk;

  ram_access_ctrl_if bus();
  ram_access_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;
  logic [7:0]  ram    [256];
  logic [7:0]  shadow [256];
  logic [31:0] exp_drd, exp_ifd;

  // ---------------- RAM model (environment, not the reference) ----------------
  logic [7:0] ra0, ra1, ra2, ra3;
  assign ra0 = bus.mem_addr;
  assign ra1 = bus.mem_addr + 8'd1;
  assign ra2 = bus.mem_addr + 8'd2;
  assign ra3 = bus.mem_addr + 8'd3;
  assign bus.mem_mfc = bus.mem_mfa & ~mfc_kill;

  always_comb begin
    bus.mem_rdata = '0;
    case (bus.mem_opcode)
      LD:      bus.mem_rdata = {ram[ra0], ram[ra1], ram[ra2], ram[ra3]};
      LDUB:    bus.mem_rdata = {24'h0, ram[ra0]};
      LDSB:    bus.mem_rdata = {{24{ram[ra0][7]}}, ram[ra0]};
      LDUH:    bus.mem_rdata = {16'h0, ram[ra0], ram[ra1]};
      LDSH:    bus.mem_rdata = {{16{ram[ra0][7]}}, ram[ra0], ram[ra1]};
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (bus.mem_mfa && bus.mem_mfc) begin
      case (bus.mem_opcode)
        STB: ram[ra0] <= bus.mem_wdata[7:0];
        STH: begin ram[ra0] <= bus.mem_wdata[15:8]; ram[ra1] <= bus.mem_wdata[7:0]; end
        ST: begin
          ram[ra0] <= bus.mem_wdata[31:24]; ram[ra1] <= bus.mem_wdata[23:16];
          ram[ra2] <= bus.mem_wdata[15:8];  ram[ra3] <= bus.mem_wdata[7:0];
        end
        default: ;
      endcase
    end
  end

  // ---------------- Reference model ----------------
  function automatic int unsigned op_size(input logic [5:0] op);
    case (op)
      LDUB, LDSB, STB: return 1;
      LDUH, LDSH, STH: return 2;
      LD, ST:          return 4;
      default:         return 0;
    endcase
  endfunction

  function automatic bit op_store(input logic [5:0] op);
    return (op == ST) || (op == STB) || (op == STH);
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return (op == LDSB) || (op == LDSH);
  endfunction

  function automatic bit misaligned(input int unsigned n, input logic [7:0] addr);
    return ALIGN_EN && (n > 1) && ((32'(addr) % n) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [7:0] addr);
    int unsigned n = op_size(op);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < n; i++) v = (v << 8) | 32'(shadow[8'(32'(addr) + i)]);
    if (op_signed(op) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [5:0] op, input logic [7:0] addr, input logic [31:0] wd);
    int unsigned n = op_size(op);
    for (int unsigned i = 0; i < n; i++)
      shadow[8'(32'(addr) + i)] = 8'((wd >> (8*(n-1-i))) & 32'hFF);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One request on port D (is_d=1) or F; checks latency, err, MFA-high cycles and data.
  task automatic access(input bit is_d, input logic [5:0] op, input logic [7:0] addr,
                        input logic [31:0] wd, input bit tmo);
    int unsigned n = op_size(op);
    bit reject = (n == 0) || misaligned(n, addr);
    int exp_lat = reject ? 1 : (tmo ? int'(TIMEOUT_CYC) + 2 : 3);
    int exp_mfa = reject ? 0 : (tmo ? int'(TIMEOUT_CYC) + 1 : 2);
    int lat = 0;
    int mfa_cnt = 0;
    bit got = 1'b0;
    logic errv;
    if (!reject && !tmo) begin
      if (op_store(op)) ref_store(op, addr, wd);
      else if (is_d)    exp_drd = ref_load(op, addr);
      else              exp_ifd = ref_load(op, addr);
    end
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_opcode = op; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    while (!got && lat < 64) begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_mfa) mfa_cnt++;
      got = is_d ? bus.d_ack : bus.if_ack;
    end
    errv = bus.err;
    bus.d_req = 1'b0;
    bus.if_req = 1'b0;
    chk(is_d ? "d_ack_seen" : "if_ack_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("err", 32'(errv), 32'(reject || tmo));
    chk("mfa_cycles", 32'(mfa_cnt), 32'(exp_mfa));
    if (is_d) chk("d_rdata", bus.d_rdata, exp_drd);
    else      chk("if_data", bus.if_data, exp_ifd);
    @(posedge clk); #1;
    chk("busy_after", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_d1, t_f, t_d2;
    logic [5:0] rop;
    logic [7:0] raddr;
    bit rdsel;
    logic [5:0] optab [10];

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_opcode = '0; bus.d_addr = '0; bus.d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      shadow[i] = ram[i];
    end
    ram[8'h10] = 8'hDE; ram[8'h11] = 8'hAD; ram[8'h12] = 8'hBE; ram[8'h13] = 8'hEF;
    shadow[8'h10] = 8'hDE; shadow[8'h11] = 8'hAD; shadow[8'h12] = 8'hBE; shadow[8'h13] = 8'hEF;
    exp_drd = '0;
    exp_ifd = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mfa", 32'(bus.mem_mfa), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_acks_err", {29'd0, bus.if_ack, bus.d_ack, bus.err}, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_if_data", bus.if_data, 32'd0);
    chk("rst_mem_bus", {18'd0, bus.mem_opcode, bus.mem_addr}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous F/D after reset: D first, then F, then a still-pending D
    bus.if_req = 1'b1; bus.if_addr = 8'h00;
    bus.d_req = 1'b1; bus.d_opcode = LDUB; bus.d_addr = 8'h11; bus.d_wdata = '0;
    t_d1 = 0; t_f = 0; t_d2 = 0;
    for (int c = 1; c <= 40 && t_d2 == 0; c++) begin
      @(posedge clk); #1;
      if (bus.d_ack) begin
        if (t_d1 == 0) begin
          t_d1 = c;
          chk("arb_d1_data", bus.d_rdata, ref_load(LDUB, 8'h11));
          bus.d_opcode = LD; bus.d_addr = 8'h10;
        end else begin
          t_d2 = c;
          chk("arb_d2_data", bus.d_rdata, ref_load(LD, 8'h10));
          bus.d_req = 1'b0;
        end
      end
      if (bus.if_ack) begin
        t_f = c;
        chk("arb_f_data", bus.if_data, ref_load(LD, 8'h00));
        bus.if_req = 1'b0;
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    chk("arb_d1_cycle", 32'(t_d1), 32'd3);
    chk("arb_f_cycle", 32'(t_f), 32'd7);
    chk("arb_d2_cycle", 32'(t_d2), 32'd11);
    exp_drd = ref_load(LD, 8'h10);
    exp_ifd = ref_load(LD, 8'h00);
    @(posedge clk); #1;

    // Store then load back
    access(1'b1, ST, 8'h10, 32'hDEADBEEF, 1'b0);
    access(1'b1, LD, 8'h10, '0, 1'b0);
    chk("st_ld_value", bus.d_rdata, 32'hDEADBEEF);

    // Unsupported opcodes
    access(1'b1, LDD, 8'h40, '0, 1'b0);
    access(1'b1, STD, 8'h44, 32'h12345678, 1'b0);

    // Misaligned halfword store, then read back the bytes
    access(1'b1, STH, 8'h21, 32'h0000CAFE, 1'b0);
    access(1'b1, LDUB, 8'h21, '0, 1'b0);
    access(1'b1, LDUB, 8'h22, '0, 1'b0);
    access(1'b0, LD, 8'h03, '0, 1'b0);
    access(1'b1, LD, 8'hFE, '0, 1'b0);

    // Timeout with MFC never arriving
    mfc_kill = 1'b1;
    access(1'b1, LD, 8'h10, '0, 1'b1);
    mfc_kill = 1'b0;

    // Randomized mix on both ports
    optab[0] = LD; optab[1] = LDUB; optab[2] = LDUH; optab[3] = LDSB; optab[4] = LDSH;
    optab[5] = ST; optab[6] = STB;  optab[7] = STH;  optab[8] = LDD;  optab[9] = 6'($urandom);
    for (int k = 0; k < 60; k++) begin
      rdsel = ($urandom_range(0, 3) != 0);
      rop = optab[$urandom_range(0, 9)];
      raddr = 8'($urandom);
      if ($urandom_range(0, 1) == 1) raddr[1:0] = 2'b00;
      if (rdsel) access(1'b1, rop, raddr, $urandom, 1'b0);
      else       access(1'b0, LD, raddr, '0, 1'b0);
    end

    // Async reset in the middle of WAIT
    mfc_kill = 1'b1;
    bus.d_req = 1'b1; bus.d_opcode = LD; bus.d_addr = 8'h10; bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_wait_mfa", 32'(bus.mem_mfa), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_mfa", 32'(bus.mem_mfa), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_data", bus.d_rdata | bus.if_data, 32'd0);
    chk("async_rst_acks", {29'd0, bus.if_ack, bus.d_ack, bus.err}, 32'd0);
    bus.d_req = 1'b0;
    mfc_kill = 1'b0;
    exp_drd = '0;
    exp_ifd = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    access(1'b1, LD, 8'h10, '0, 1'b0);
    access(1'b0, LD, 8'h10, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
